// File: rtl/noise_var_est_pkg.sv
// Shared defaults, FSM encoding and width helpers for the noise-variance estimator.
package noise_var_est_pkg;

  localparam int N_FFT_DEF  = 512;
  localparam int LOG2_N_DEF = 9;
  localparam int DW_DEF     = 12;
  localparam int OW_DEF     = 12;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD1 = 3'd1;
  localparam logic [2:0] ST_LOAD2 = 3'd2;
  localparam logic [2:0] ST_CALC  = 3'd3;
  localparam logic [2:0] ST_OUT   = 3'd4;

  // Room for N squared magnitudes of (DW+1)-bit differences.
  function automatic int acc_width(input int dw, input int log2n);
    return 2 * dw + 2 + log2n;
  endfunction

  function automatic int sat_limit(input int ow);
    return (1 << (ow - 1)) - 1;
  endfunction

endpackage

// File: rtl/nve_sym_buf.sv
// Simple dual-port symbol buffer with a registered read port, shaped for block RAM inference.
module nve_sym_buf
  import noise_var_est_pkg::*;
#(
  parameter int DEPTH = N_FFT_DEF,
  parameter int AW    = LOG2_N_DEF,
  parameter int WIDTH = 2 * DW_DEF
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/noise_var_est.sv
// Noise-variance estimator: sigma2 = sum|LTF2-LTF1|^2 / (2N), emitted as an N-cycle burst.
// Optional macro NVE_SMOOTH_EN enables an inter-frame IIR on the estimate.
module noise_var_est
  import noise_var_est_pkg::*;
#(
  parameter int N_FFT  = N_FFT_DEF,
  parameter int LOG2_N = LOG2_N_DEF,
  parameter int DW     = DW_DEF,
  parameter int OW     = OW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 di_sop,
  input  logic signed [DW-1:0] di_re,
  input  logic signed [DW-1:0] di_im,
  input  logic                 di_vld,
  output logic signed [OW-1:0] do_data,
  output logic                 do_vld,
  output logic                 busy,
  output logic                 err
);

  localparam int SQ_W    = 2 * DW + 2;
  localparam int ACC_W   = acc_width(DW, LOG2_N);
  localparam int SN_W    = ACC_W - LOG2_N - 1;
  localparam int FILT_W  = SN_W + 2;
  localparam int SAT_MAX = sat_limit(OW);
  localparam logic [LOG2_N-1:0] LAST_IDX = LOG2_N'(N_FFT - 1);

  logic [2:0]               state;
  logic [LOG2_N-1:0]        idx;
  logic                     start;
  logic                     buf_we;
  logic [LOG2_N-1:0]        buf_waddr;
  logic [2*DW-1:0]          rd_data;
  logic signed [DW-1:0]     s1_re, s1_im;
  logic signed [DW-1:0]     s2_re, s2_im;
  logic signed [DW:0]       d_re, d_im;
  logic signed [SQ_W-1:0]   d_re_w, d_im_w;
  logic [SQ_W-1:0]          sq_re, sq_im, mag;
  logic                     v0, v1, v2;
  logic                     pipe_empty;
  logic [ACC_W-1:0]         acc;
  logic [SN_W-1:0]          s_new;

  assign start      = di_vld && di_sop;
  assign busy       = (state != ST_IDLE);
  assign pipe_empty = !(v0 || v1 || v2);
  assign s_new      = acc[ACC_W-1:LOG2_N+1];

  // Symbol 1 is written while loading; any accepted sop rewrites entry 0.
  assign buf_we    = (((state == ST_IDLE) || (state == ST_LOAD1) || (state == ST_LOAD2)) && start)
                     || ((state == ST_LOAD1) && di_vld);
  assign buf_waddr = start ? '0 : idx;

  nve_sym_buf #(
    .DEPTH (N_FFT),
    .AW    (LOG2_N),
    .WIDTH (2 * DW)
  ) u_sym_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (buf_waddr),
    .wdata ({di_re, di_im}),
    .raddr (idx),
    .rdata (rd_data)
  );

  assign s1_re  = rd_data[2*DW-1:DW];
  assign s1_im  = rd_data[DW-1:0];
  assign d_re   = {s2_re[DW-1], s2_re} - {s1_re[DW-1], s1_re};
  assign d_im   = {s2_im[DW-1], s2_im} - {s1_im[DW-1], s1_im};
  assign d_re_w = SQ_W'(d_re);
  assign d_im_w = SQ_W'(d_im);

  function automatic logic [OW-1:0] sat_clamp(input logic [FILT_W-1:0] v);
    if (v > FILT_W'(SAT_MAX)) return OW'(SAT_MAX);
    else if (v == '0)         return OW'(1);
    else                      return v[OW-1:0];
  endfunction

`ifdef NVE_SMOOTH_EN
  logic              calc_phase;
  logic              have_prev;
  logic [SN_W-1:0]   s_new_q;
  logic [FILT_W-1:0] prev_ext;
  logic [FILT_W-1:0] filt;

  // The previously emitted value is still held on do_data, so it doubles as s_prev.
  assign prev_ext = FILT_W'(unsigned'(do_data));
  assign filt     = (prev_ext + (prev_ext << 1) + FILT_W'(s_new_q) + FILT_W'(2)) >> 2;
`endif

  // Control FSM, square/accumulate pipeline (read, square, sum, accumulate) and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      idx     <= '0;
      s2_re   <= '0;
      s2_im   <= '0;
      sq_re   <= '0;
      sq_im   <= '0;
      mag     <= '0;
      v0      <= 1'b0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      acc     <= '0;
      do_data <= '0;
      do_vld  <= 1'b0;
      err     <= 1'b0;
`ifdef NVE_SMOOTH_EN
      calc_phase <= 1'b0;
      have_prev  <= 1'b0;
      s_new_q    <= '0;
`endif
    end else begin
      v0    <= 1'b0;
      v1    <= v0;
      v2    <= v1;
      sq_re <= d_re_w * d_re_w;
      sq_im <= d_im_w * d_im_w;
      mag   <= sq_re + sq_im;
      err   <= 1'b0;
      if (v2) acc <= acc + ACC_W'(mag);

      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_LOAD1;
            idx   <= LOG2_N'(1);
            acc   <= '0;
          end
        end

        ST_LOAD1: begin
          if (start) begin
            idx <= LOG2_N'(1);
            acc <= '0;
          end else if (di_vld) begin
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= ST_LOAD2;
            end else begin
              idx <= idx + LOG2_N'(1);
            end
          end
        end

        ST_LOAD2: begin
          if (start) begin
            state <= ST_LOAD1;
            idx   <= LOG2_N'(1);
            acc   <= '0;
            v1    <= 1'b0;
            v2    <= 1'b0;
          end else if (di_vld) begin
            v0    <= 1'b1;
            s2_re <= di_re;
            s2_im <= di_im;
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= ST_CALC;
            end else begin
              idx <= idx + LOG2_N'(1);
            end
          end
        end

        ST_CALC: begin
          if (pipe_empty) begin
`ifdef NVE_SMOOTH_EN
            if (!calc_phase) begin
              s_new_q    <= s_new;
              calc_phase <= 1'b1;
            end else begin
              calc_phase <= 1'b0;
              have_prev  <= 1'b1;
              do_data    <= sat_clamp(have_prev ? filt : FILT_W'(s_new_q));
              do_vld     <= 1'b1;
              state      <= ST_OUT;
            end
`else
            do_data <= sat_clamp(FILT_W'(s_new));
            do_vld  <= 1'b1;
            state   <= ST_OUT;
`endif
          end
        end

        ST_OUT: begin
          err <= start;
          if (idx == LAST_IDX) begin
            idx    <= '0;
            do_vld <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            idx <= idx + LOG2_N'(1);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noise_var_est.sv
// Randomized self-checking bench for noise_var_est against an array-based reference model.
module tb_noise_var_est;

  localparam int N  = 512;
  localparam int DW = 12;
  localparam int OW = 12;
`ifdef NVE_SMOOTH_EN
  localparam int EXP_LAT = 5;
`else
  localparam int EXP_LAT = 4;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 di_sop;
  logic                 di_vld;
  logic signed [DW-1:0] di_re;
  logic signed [DW-1:0] di_im;
  logic signed [OW-1:0] do_data;
  logic                 do_vld;
  logic                 busy;
  logic                 err;

  int n_cmp  = 0;
  int n_fail = 0;

  int s1_re [N];
  int s1_im [N];
  int s2_re [N];
  int s2_im [N];
  int ref_prev      = 0;
  bit ref_have_prev = 1'b0;

  always #5 clk = ~clk;

  noise_var_est dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .di_sop  (di_sop),
    .di_re   (di_re),
    .di_im   (di_im),
    .di_vld  (di_vld),
    .do_data (do_data),
    .do_vld  (do_vld),
    .busy    (busy),
    .err     (err)
  );

  initial begin
    #3ms;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Reference model: plain sums over the stored symbols.
  function automatic longint rawEstimate();
    longint sum = 0;
    for (int i = 0; i < N; i++) begin
      longint dr = longint'(s2_re[i] - s1_re[i]);
      longint di = longint'(s2_im[i] - s1_im[i]);
      sum += dr * dr + di * di;
    end
    return sum / (2 * N);
  endfunction

  function automatic int clampEst(input longint v);
    if (v > 2047) return 2047;
    if (v < 1) return 1;
    return int'(v);
  endfunction

  function automatic int expectedOutput();
    longint raw = rawEstimate();
`ifdef NVE_SMOOTH_EN
    if (ref_have_prev) return clampEst((3 * longint'(ref_prev) + raw + 2) / 4);
`endif
    return clampEst(raw);
  endfunction

  function automatic int clip12(input int v);
    if (v > 2047) return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  task automatic setConst(input int r1, input int i1, input int dr, input int di);
    for (int i = 0; i < N; i++) begin
      s1_re[i] = r1;
      s1_im[i] = i1;
      s2_re[i] = r1 + dr;
      s2_im[i] = i1 + di;
    end
  endtask

  task automatic setRandom(input int noise);
    for (int i = 0; i < N; i++) begin
      s1_re[i] = int'($urandom_range(0, 4095)) - 2048;
      s1_im[i] = int'($urandom_range(0, 4095)) - 2048;
      s2_re[i] = clip12(s1_re[i] + int'($urandom_range(0, 2 * noise)) - noise);
      s2_im[i] = clip12(s1_im[i] + int'($urandom_range(0, 2 * noise)) - noise);
    end
  endtask

  task automatic driveCycle(input logic vld, input logic sop, input int re, input int im);
    di_vld = vld;
    di_sop = sop;
    di_re  = DW'(re);
    di_im  = DW'(im);
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int gap_pct);
    for (int i = 0; i < 2 * N; i++) begin
      int idle = 0;
      while (gap_pct > 0 && idle < 4 && $urandom_range(0, 99) < gap_pct) begin
        driveCycle(1'b0, 1'($urandom_range(0, 1)), int'($urandom), int'($urandom));
        idle++;
      end
      if (i < N) driveCycle(1'b1, i == 0, s1_re[i], s1_im[i]);
      else       driveCycle(1'b1, 1'b0, s2_re[i-N], s2_im[i-N]);
    end
    di_vld = 1'b0;
    di_sop = 1'b0;
  endtask

  task automatic checkBurst(input string tag, input int exp_val, input int inject_at);
    int   lat = 0;
    int   len = 0;
    int   changes = 0;
    int   errs = 0;
    logic [OW-1:0] first;
    while (!do_vld && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput({tag, "_latency"}, lat, EXP_LAT);
    if (do_vld) begin
      first = do_data;
      checkOutput({tag, "_value"}, do_data, exp_val);
      while (do_vld && len < 2 * N) begin
        len++;
        if (do_data !== first) changes++;
        if (err) errs++;
        if (inject_at > 0 && len == inject_at) begin
          di_vld = 1'b1;
          di_sop = 1'b1;
          di_re  = DW'($urandom);
        end else begin
          di_vld = 1'b0;
          di_sop = 1'b0;
        end
        @(posedge clk);
        #1;
      end
      if (err) errs++;
      checkOutput({tag, "_burst_len"}, len, N);
      checkOutput({tag, "_burst_stable"}, changes, 0);
      checkOutput({tag, "_err_pulses"}, errs, (inject_at > 0) ? 1 : 0);
      checkOutput({tag, "_busy_after"}, busy, 0);
      checkOutput({tag, "_hold"}, do_data, exp_val);
    end
  endtask

  task automatic runFrame(input string tag, input int gap_pct, input int inject_at);
    int exp_val;
    exp_val = expectedOutput();
    applyStimulus(gap_pct);
    checkOutput({tag, "_busy_calc"}, busy, 1);
    checkBurst(tag, exp_val, inject_at);
    ref_prev      = exp_val;
    ref_have_prev = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    di_vld = 1'b0;
    di_sop = 1'b0;
    di_re  = '0;
    di_im  = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_do", do_data, 0);
    checkOutput("reset_do_vld", do_vld, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    setConst(100, -50, 0, 0);
    runFrame("identical", 0, 0);

    setConst(300, 200, 4, 0);
    runFrame("plus4", 0, 0);

    setConst(-2048, -2048, 4095, 4095);
    runFrame("extreme", 0, 0);

    setConst(-700, 55, 4, 0);
    runFrame("plus4_gaps", 30, 0);

    // Partial pair (sym1 + 200 sym2 samples), then restart with a clean pair and an sop during OUT.
    setConst(-300, 700, 8, 0);
    for (int i = 0; i < N + 200; i++)
      driveCycle(1'b1, i == 0, int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048);
    runFrame("abort_plus8", 0, 100);

    begin
      int noise_tab [4] = '{3, 20, 60, 400};
      for (int k = 0; k < 4; k++) begin
        setRandom(noise_tab[k]);
        runFrame($sformatf("rand%0d", k), (k % 2) * 20, 0);
      end
    end

    // Reset in the middle of symbol 2.
    for (int i = 0; i < N + 100; i++)
      driveCycle(1'b1, i == 0, int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048);
    rst_n = 1'b0;
    #2;
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_do", do_data, 0);
    checkOutput("midreset_do_vld", do_vld, 0);
    checkOutput("midreset_err", err, 0);
    ref_prev      = 0;
    ref_have_prev = 1'b0;
    di_vld = 1'b0;
    di_sop = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    setConst(0, 0, 4, 0);
    runFrame("after_reset", 0, 0);

    setConst(1000, -1000, 8, 0);
    runFrame("second_after_reset", 10, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/noise_var_est.md
Name: noise_var_est

Overview:
- Producer of the per-subcarrier noise-variance stream consumed by the payload noise-calculation stage (which forms Kf = 1578/sigma2).
- Takes two repeated frequency-domain long-training symbols (N_FFT complex samples each) and computes sigma2 from their difference energy.
- Emits sigma2 as one contiguous N_FFT-cycle burst, matching the consumer's 512-sample counter framing.

Parameters:
- N_FFT, 512, subcarriers per symbol (power of two)
- LOG2_N, 9, log2(N_FFT)
- DW, 12, input I/Q sample width (signed)
- OW, 12, output width (signed, value always positive)

Ports:
- clk  in  1  working clock
- rst_n  in  1  asynchronous reset, active low
- di_sop  in  1  marks first sample of training symbol 1; valid only with di_vld
- di_re  in  DW  signed real part
- di_im  in  DW  signed imag part
- di_vld  in  1  input sample valid
- do  out  OW  sigma2, signed, range 1..2^(OW-1)-1
- do_vld  out  1  output valid, contiguous N_FFT cycles per estimate
- busy  out  1  high in every state except IDLE
- err  out  1  one-cycle pulse: di_sop received during OUT

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM to IDLE, counters, accumulator and square pipeline cleared. Symbol buffer contents are don't-care.
- FSM states:
  - IDLE: waits for di_vld&&di_sop, then enters LOAD1; that sample is index 0.
  - LOAD1: writes each valid sample to buffer[idx], 2*DW bits per entry. At idx N_FFT-1 goes to LOAD2 with idx reset to 0.
  - LOAD2: per valid sample, reads buffer[idx] and forms dr = re2-re1 and di = im2-im1 (DW+1 bits each). Computes |d|^2 = dr^2+di^2 (2*DW+2 bits) through a 2-stage pipeline and accumulates into a 2*DW+2+LOG2_N bit accumulator. After the last sample it goes to CALC.
  - CALC: waits for the pipeline to drain, then computes s = acc >> (LOG2_N+1), i.e. sum/(2N), since the difference doubles the noise. s is saturated to 2^(OW-1)-1 and clamped to a minimum of 1 to avoid divide-by-zero downstream. s is registered into do, then FSM goes to OUT.
  - OUT: do_vld=1 for exactly N_FFT consecutive cycles with do constant, then IDLE.
- Gaps in di_vld are allowed inside LOAD1/LOAD2; only valid cycles advance idx.
- Latency: first do_vld occurs exactly 4 clk after the cycle the last symbol-2 sample is sampled (2 pipeline stages, 1 CALC, 1 output register).
- di_sop with di_vld in LOAD1/LOAD2: abort, restart LOAD1 with that sample as index 0, accumulator cleared.
- In OUT: all inputs ignored. di_sop&&di_vld pulses err the next cycle; the burst continues unchanged.
- di_vld in CALC: ignored, no err.
- do holds its last value after the burst; do_vld returns to 0.
- Reset mid-operation: immediate return to IDLE with do_vld=0.

Optional Feature:
- Macro: NVE_SMOOTH_EN
- Defined: inter-frame IIR, s_out = (3*s_prev + s_new + 2) >> 2, computed in CALC.
  - s_prev is the last emitted value, reset to 0.
  - The first estimate after reset bypasses the IIR.
  - Saturation and min-1 clamp apply after filtering.
  - CALC takes 1 extra cycle, so latency is 5.
- Undefined: raw s_new output, latency 4.

Decomposition:
- Shared package: N_FFT, LOG2_N, DW, OW defaults; FSM state encoding (IDLE, LOAD1, LOAD2, CALC, OUT); derived accumulator width; saturation limit constant.
- One sub-module: nve_sym_buf, a simple dual-port N_FFT x 2*DW RAM with 1-cycle read latency, inferable as block RAM.
- Squarer/accumulator pipeline stays inline.

Test Plan:
- Symbol1 all (100,-50), symbol2 identical -> acc=0, do=1 (min clamp), do_vld high exactly 512 cycles, rising 4 clk after the last input.
- Symbol2 = symbol1 + (4,0) on every bin -> acc=8192, do=8.
- Symbol1 all (-2048,-2048), symbol2 all (2047,2047) -> acc=17171481600 (no overflow), do=2047 (saturated).
- Random di_vld gaps (~30% idle) with the +(4,0) pattern -> do=8, identical to the gapless run; do_vld still contiguous.
- di_sop re-asserted at symbol-2 index 200, then two clean symbols with +(8,0) -> do=32 (first partial pair discarded). di_sop during OUT -> err pulse next cycle, burst unchanged. rst_n low mid-LOAD2 -> busy=0, do=0, do_vld=0.
- NVE_SMOOTH_EN defined: frame1 do=8, frame2 raw 32 -> do=(24+32+2)>>2=14, latency 5.
